// File: rtl/l2_reqarb.sv
// Round-robin merge of icache/dcache requests onto one l2 port, with an in-order
// source FIFO that steers each l2 response back to its issuer. Optional counters: L2ARB_STATS_EN.
module l2_reqarb #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req_valid,
  input  logic [29:0] ic_req_addr,
  output logic        ic_req_ready,
  input  logic        dc_req_valid,
  input  logic [1:0]  dc_req_op,
  input  logic [29:0] dc_req_addr,
  input  logic [3:0]  dc_req_wmask,
  input  logic [31:0] dc_req_wdata,
  output logic        dc_req_ready,
  output logic        req_valid,
  output logic [1:0]  req_op,
  output logic [29:0] req_addr,
  output logic [3:0]  req_wmask,
  output logic [31:0] req_wdata,
  input  logic        l2_req_ready,
  input  logic        l2_resp_valid,
  input  logic        l2_resp_error,
  input  logic [63:0] l2_resp_rdata,
  output logic        resp_ready,
  output logic        ic_resp_valid,
  output logic        ic_resp_error,
  output logic [63:0] ic_resp_rdata,
  input  logic        ic_resp_ready,
  output logic        dc_resp_valid,
  output logic        dc_resp_error,
  output logic [63:0] dc_resp_rdata,
  input  logic        dc_resp_ready
`ifdef L2ARB_STATS_EN
  ,
  output logic [31:0] ic_req_count,
  output logic [31:0] dc_req_count,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [DEPTH-1:0] r_src;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_rr_last;
  logic             r_lock;
  logic             r_lock_src;

  logic w_full;
  logic w_empty;
  logic w_grant;
  logic w_accept;
  logic w_pop;
  logic w_head;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));
  assign w_head  = r_src[r_rd_ptr];

  // Grant: 0 = icache, 1 = dcache; a stalled request keeps its grant until taken
  always_comb begin
    w_grant = 1'b0;
    if (r_lock)
      w_grant = r_lock_src;
    else if (ic_req_valid && dc_req_valid)
      w_grant = ~r_rr_last;
    else
      w_grant = dc_req_valid;
  end

  assign req_valid    = (ic_req_valid | dc_req_valid) & ~w_full & ~rst;
  assign w_accept     = req_valid & l2_req_ready;
  assign ic_req_ready = w_accept & ~w_grant;
  assign dc_req_ready = w_accept & w_grant;

  always_comb begin
    req_op    = 2'b00;
    req_addr  = ic_req_addr;
    req_wmask = 4'h0;
    req_wdata = 32'h0;
    if (w_grant) begin
      req_op    = dc_req_op;
      req_addr  = dc_req_addr;
      req_wmask = dc_req_wmask;
      req_wdata = dc_req_wdata;
    end
  end

  assign ic_resp_valid = l2_resp_valid & ~w_empty & ~w_head;
  assign dc_resp_valid = l2_resp_valid & ~w_empty & w_head;
  assign ic_resp_error = l2_resp_error;
  assign dc_resp_error = l2_resp_error;
  assign ic_resp_rdata = l2_resp_rdata;
  assign dc_resp_rdata = l2_resp_rdata;
  assign resp_ready    = ~w_empty & (w_head ? dc_resp_ready : ic_resp_ready);
  assign w_pop         = l2_resp_valid & resp_ready;

  // Source FIFO; a push never coincides with full, so the count cannot overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_src[r_wr_ptr] <= w_grant;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_last  <= 1'b0;
      r_lock     <= 1'b0;
      r_lock_src <= 1'b0;
    end else if (w_accept) begin
      r_rr_last <= w_grant;
      r_lock    <= 1'b0;
    end else if (req_valid) begin
      r_lock     <= 1'b1;
      r_lock_src <= w_grant;
    end
  end

`ifdef L2ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ic_req_count <= 32'd0;
      dc_req_count <= 32'd0;
      stall_cycles <= 32'd0;
    end else begin
      if (ic_req_ready)
        ic_req_count <= ic_req_count + 32'd1;
      if (dc_req_ready)
        dc_req_count <= dc_req_count + 32'd1;
      if (req_valid && !l2_req_ready)
        stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_reqarb.sv
// Self-checking bench for l2_reqarb: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the arbiter and source FIFO.
module tb_l2_reqarb;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        ic_req_valid;
  logic [29:0] ic_req_addr;
  logic        ic_req_ready;
  logic        dc_req_valid;
  logic [1:0]  dc_req_op;
  logic [29:0] dc_req_addr;
  logic [3:0]  dc_req_wmask;
  logic [31:0] dc_req_wdata;
  logic        dc_req_ready;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [29:0] req_addr;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;
  logic        l2_req_ready;
  logic        l2_resp_valid;
  logic        l2_resp_error;
  logic [63:0] l2_resp_rdata;
  logic        resp_ready;
  logic        ic_resp_valid;
  logic        ic_resp_error;
  logic [63:0] ic_resp_rdata;
  logic        ic_resp_ready;
  logic        dc_resp_valid;
  logic        dc_resp_error;
  logic [63:0] dc_resp_rdata;
  logic        dc_resp_ready;
`ifdef L2ARB_STATS_EN
  logic [31:0] ic_req_count;
  logic [31:0] dc_req_count;
  logic [31:0] stall_cycles;
`endif

  l2_reqarb #(.DEPTH(DEPTH)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .ic_req_valid  (ic_req_valid),
    .ic_req_addr   (ic_req_addr),
    .ic_req_ready  (ic_req_ready),
    .dc_req_valid  (dc_req_valid),
    .dc_req_op     (dc_req_op),
    .dc_req_addr   (dc_req_addr),
    .dc_req_wmask  (dc_req_wmask),
    .dc_req_wdata  (dc_req_wdata),
    .dc_req_ready  (dc_req_ready),
    .req_valid     (req_valid),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wmask     (req_wmask),
    .req_wdata     (req_wdata),
    .l2_req_ready  (l2_req_ready),
    .l2_resp_valid (l2_resp_valid),
    .l2_resp_error (l2_resp_error),
    .l2_resp_rdata (l2_resp_rdata),
    .resp_ready    (resp_ready),
    .ic_resp_valid (ic_resp_valid),
    .ic_resp_error (ic_resp_error),
    .ic_resp_rdata (ic_resp_rdata),
    .ic_resp_ready (ic_resp_ready),
    .dc_resp_valid (dc_resp_valid),
    .dc_resp_error (dc_resp_error),
    .dc_resp_rdata (dc_resp_rdata),
    .dc_resp_ready (dc_resp_ready)
`ifdef L2ARB_STATS_EN
    ,
    .ic_req_count  (ic_req_count),
    .dc_req_count  (dc_req_count),
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of outstanding sources (0 = ic, 1 = dc), last winner, held grant
  bit mq[$];
  bit m_rr;
  bit m_lock;
  bit m_lock_src;
  int m_ic_cnt, m_dc_cnt, m_stall;
  bit e_g, e_rv, e_acc, e_pop;
  bit ic_took, dc_took;

  task automatic eval();
    bit empty, full, head, e_rr;
    #1;
    if (rst) begin
      mq.delete();
      m_rr = 1'b0; m_lock = 1'b0; m_lock_src = 1'b0;
      m_ic_cnt = 0; m_dc_cnt = 0; m_stall = 0;
    end
    empty = (mq.size() == 0);
    full  = (mq.size() == DEPTH);
    head  = empty ? 1'b0 : mq[0];
    e_g   = m_lock ? m_lock_src : ((ic_req_valid && dc_req_valid) ? !m_rr : dc_req_valid);
    e_rv  = (ic_req_valid || dc_req_valid) && !full && !rst;
    e_acc = e_rv && l2_req_ready;
    e_rr  = !empty && (head ? dc_resp_ready : ic_resp_ready);
    e_pop = l2_resp_valid && e_rr;
    chk("req_valid", 64'(req_valid), 64'(e_rv));
    chk("ic_req_ready", 64'(ic_req_ready), 64'(e_acc && !e_g));
    chk("dc_req_ready", 64'(dc_req_ready), 64'(e_acc && e_g));
    if (e_rv) begin
      chk("req_op", 64'(req_op), e_g ? 64'(dc_req_op) : 64'd0);
      chk("req_addr", 64'(req_addr), e_g ? 64'(dc_req_addr) : 64'(ic_req_addr));
      chk("req_wmask", 64'(req_wmask), e_g ? 64'(dc_req_wmask) : 64'd0);
      chk("req_wdata", 64'(req_wdata), e_g ? 64'(dc_req_wdata) : 64'd0);
    end
    chk("ic_resp_valid", 64'(ic_resp_valid), 64'(l2_resp_valid && !empty && !head));
    chk("dc_resp_valid", 64'(dc_resp_valid), 64'(l2_resp_valid && !empty && head));
    chk("resp_ready", 64'(resp_ready), 64'(e_rr));
    chk("ic_resp_rdata", ic_resp_rdata, l2_resp_rdata);
    chk("dc_resp_rdata", dc_resp_rdata, l2_resp_rdata);
    chk("resp_error", 64'({ic_resp_error, dc_resp_error}), 64'({l2_resp_error, l2_resp_error}));
`ifdef L2ARB_STATS_EN
    chk("ic_req_count", 64'(ic_req_count), 64'(m_ic_cnt));
    chk("dc_req_count", 64'(dc_req_count), 64'(m_dc_cnt));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    ic_took = 1'b0;
    dc_took = 1'b0;
    if (!rst) begin
      if (e_pop) void'(mq.pop_front());
      if (e_acc) begin
        mq.push_back(e_g);
        m_rr   = e_g;
        m_lock = 1'b0;
        if (e_g) begin m_dc_cnt++; dc_took = 1'b1; end
        else     begin m_ic_cnt++; ic_took = 1'b1; end
      end else if (e_rv) begin
        m_lock     = 1'b1;
        m_lock_src = e_g;
        m_stall++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ic_req_valid  = 1'b0; ic_req_addr = 30'h0;
    dc_req_valid  = 1'b0; dc_req_op = 2'b00; dc_req_addr = 30'h0;
    dc_req_wmask  = 4'h0; dc_req_wdata = 32'h0;
    l2_req_ready  = 1'b0; l2_resp_valid = 1'b0; l2_resp_error = 1'b0;
    l2_resp_rdata = 64'h0; ic_resp_ready = 1'b0; dc_resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ic_req_valid = 1'b1;
    rst = 1'b1;
    eval();
    adv();
    rst = 1'b0;
    ic_req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);

    // Both requesters busy, l2 always ready: grants alternate starting with dc
    do_reset();
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; l2_req_ready = 1'b1;
    l2_resp_valid = 1'b1; ic_resp_ready = 1'b1; dc_resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ic_req_addr = 30'(i); dc_req_addr = 30'(100 + i);
      l2_resp_rdata = 64'(i);
      eval();
      chk("alt_dc", 64'(dc_req_ready), 64'(i % 2 == 0));
      chk("alt_ic", 64'(ic_req_ready), 64'(i % 2 == 1));
      chk("alt_resp_dc", 64'(dc_resp_valid), 64'(i % 2 == 1));
      adv();
    end

    // Stalled dc request keeps its grant while ic rises
    do_reset();
    dc_req_valid = 1'b1; dc_req_op = 2'b01; dc_req_addr = 30'h0400_0010;
    dc_req_wmask = 4'hF; dc_req_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin ic_req_valid = 1'b1; ic_req_addr = 30'h55; end
      eval();
      chk("lock_addr", 64'(req_addr), 64'h0400_0010);
      chk("lock_op", 64'(req_op), 64'd1);
      chk("lock_dcrdy", 64'(dc_req_ready), 64'd0);
      adv();
    end
    l2_req_ready = 1'b1;
    eval();
    chk("lock_release", 64'(dc_req_ready), 64'd1);
    adv();
    dc_req_valid = 1'b0;
    eval();
    chk("ic_next", 64'(ic_req_ready), 64'd1);
    adv();

    // Fill with ic requests; a pop on the full cycle does not allow a same-cycle push
    do_reset();
    ic_req_valid = 1'b1; l2_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ic_req_addr = 30'(i + 8);
      eval();
      chk("fill_acc", 64'(ic_req_ready), 64'd1);
      adv();
    end
    eval();
    chk("full_block", 64'(req_valid), 64'd0);
    adv();
    l2_resp_valid = 1'b1; ic_resp_ready = 1'b1;
    eval();
    chk("full_pop", 64'(resp_ready), 64'd1);
    chk("full_nopush", 64'(req_valid), 64'd0);
    adv();
    l2_resp_valid = 1'b0;
    eval();
    chk("push_after_pop", 64'(ic_req_ready), 64'd1);
    adv();

    // dc head with dc back-pressured: response waits, then delivers
    do_reset();
    dc_req_valid = 1'b1; l2_req_ready = 1'b1;
    eval();
    adv();
    dc_req_valid = 1'b0;
    l2_resp_valid = 1'b1; l2_resp_rdata = 64'hDEAD_BEEF_0123_4567;
    dc_resp_ready = 1'b0; ic_resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      eval();
      chk("bp_dcv", 64'(dc_resp_valid), 64'd1);
      chk("bp_rdy", 64'(resp_ready), 64'd0);
      chk("bp_icv", 64'(ic_resp_valid), 64'd0);
      adv();
    end
    dc_resp_ready = 1'b1;
    eval();
    chk("bp_deliver", 64'(resp_ready), 64'd1);
    chk("bp_data", dc_resp_rdata, 64'hDEAD_BEEF_0123_4567);
    adv();

    // Response on empty FIFO stalls; reset mid-traffic discards outstanding sources
    do_reset();
    l2_resp_valid = 1'b1; ic_resp_ready = 1'b1; dc_resp_ready = 1'b1;
    eval();
    chk("empty_rdy", 64'(resp_ready), 64'd0);
    chk("empty_icv", 64'(ic_resp_valid), 64'd0);
    chk("empty_dcv", 64'(dc_resp_valid), 64'd0);
    adv();
    l2_resp_valid = 1'b0; ic_req_valid = 1'b1; l2_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin eval(); adv(); end
    rst = 1'b1;
    eval();
    chk("rst_rv", 64'(req_valid), 64'd0);
    adv();
    eval();
    chk("rst_rv_hold", 64'(req_valid), 64'd0);
    adv();
    rst = 1'b0; ic_req_valid = 1'b0; l2_resp_valid = 1'b1;
    eval();
    chk("rst_empty", 64'(resp_ready), 64'd0);
    adv();

`ifdef L2ARB_STATS_EN
    // 2 stalls, then 5 ic and 3 dc accepts
    do_reset();
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; l2_req_ready = 1'b0;
    l2_resp_valid = 1'b1; ic_resp_ready = 1'b1; dc_resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin eval(); adv(); end
    l2_req_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin eval(); adv(); end
    dc_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin eval(); adv(); end
    ic_req_valid = 1'b0;
    eval();
    chk("stat_ic", 64'(ic_req_count), 64'd5);
    chk("stat_dc", 64'(dc_req_count), 64'd3);
    chk("stat_stall", 64'(stall_cycles), 64'd2);
    adv();
`endif

    // Randomized traffic; requesters hold valid and payload until accepted
    do_reset();
    ic_took = 1'b0; dc_took = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!ic_req_valid || ic_took) begin
        ic_req_valid = ($urandom_range(0, 2) != 0);
        ic_req_addr  = 30'($urandom);
      end
      if (!dc_req_valid || dc_took) begin
        dc_req_valid = ($urandom_range(0, 2) != 0);
        dc_req_op    = 2'($urandom);
        dc_req_addr  = 30'($urandom);
        dc_req_wmask = 4'($urandom);
        dc_req_wdata = $urandom;
      end
      l2_req_ready  = ($urandom_range(0, 3) != 0);
      l2_resp_valid = ($urandom_range(0, 2) == 0);
      l2_resp_error = 1'($urandom);
      l2_resp_rdata = {$urandom, $urandom};
      ic_resp_ready = ($urandom_range(0, 3) != 0);
      dc_resp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 299) == 0);
      eval();
      adv();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
